// File: rtl/mult_arb.sv
// -----------------------------------------------------------------------------
// mult_arb
//
// Purpose
//   Shares one external 8x8 sequential multiplier between N_REQ requesters.
//   A round-robin arbiter picks one pending requester while idle, latches its
//   operands onto the multiplier port, runs the start/busy handshake, and then
//   returns the 16-bit product with a one-cycle done pulse on the owner's bit.
//
// Parameters
//   N_REQ        number of requesters (2..8)
//   ID_W         width of a requester index (>= clog2(N_REQ))
//
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_ni       asynchronous active-low reset
//   req_i        per-requester level request, held until its done bit is seen
//   a_bi, b_bi   packed operands, byte k belongs to requester k
//   gnt_o        one-hot owner of the multiplier (START through RESP)
//   done_o       one-cycle pulse on the owner bit when res_bo is valid
//   res_bo       product of the last completed operation
//   res_id_o     index of the requester that owns res_bo
//   err_o        high together with done_o when the watchdog aborted the op
//   mul_a_bo     operand A driven to the multiplier
//   mul_b_bo     operand B driven to the multiplier
//   mul_start_o  start strobe to the multiplier (high for the whole START state)
//   mul_busy_i   multiplier busy flag
//   mul_y_bi     multiplier product
//   mul_rst_o    active-high synchronous reset to the multiplier
//
// Configuration
//   MULT_ARB_WATCHDOG_EN  when defined, a watchdog aborts a stuck handshake:
//                         START longer than 4 cycles without busy, or BUSY
//                         longer than 15 cycles, pulses mul_rst_o for one
//                         cycle and finishes the operation with err_o=1 and a
//                         zero result. When undefined, err_o is tied low and
//                         the FSM waits on the multiplier indefinitely.
// -----------------------------------------------------------------------------
module mult_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [8*N_REQ-1:0] a_bi,
  input  logic [8*N_REQ-1:0] b_bi,
  output logic [N_REQ-1:0]   gnt_o,
  output logic [N_REQ-1:0]   done_o,
  output logic [15:0]        res_bo,
  output logic [ID_W-1:0]    res_id_o,
  output logic               err_o,
  output logic [7:0]         mul_a_bo,
  output logic [7:0]         mul_b_bo,
  output logic               mul_start_o,
  input  logic               mul_busy_i,
  input  logic [15:0]        mul_y_bi,
  output logic               mul_rst_o
);

  // One extra bit so that "index + N_REQ" fits while computing distances.
  localparam int DW = ID_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [N_REQ-1:0]  r_gnt;
  logic [ID_W-1:0]   r_last;     // last served index; also the current owner
  logic [ID_W-1:0]   r_res_id;
  logic [7:0]        r_mul_a;
  logic [7:0]        r_mul_b;
  logic [15:0]       r_res;
  logic              r_mul_rst;

  logic              w_grant;
  logic              w_complete;
  logic              w_abort;
  logic              w_wd_fire;
  logic              w_any_req;

  logic [N_REQ-1:0]  w_win_oh;
  logic [ID_W-1:0]   w_win_idx;
  logic [7:0]        w_win_a;
  logic [7:0]        w_win_b;

  // Round-robin distance of each requester from the search start point
  // (r_last + 1). Distance 0 is searched first, N_REQ-1 last.
  logic [DW-1:0]     w_dist [N_REQ];

  assign w_any_req = |req_i;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter and operand select.
  // Requester gi wins when it requests and no other requester with a smaller
  // distance also requests. The winner's index and operands are collected by
  // an OR chain across the generate blocks (only one term is non-zero).
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      logic [N_REQ-1:0] w_ahead;
      logic [ID_W-1:0]  w_idx_term;
      logic [7:0]       w_a_term;
      logic [7:0]       w_b_term;
      logic [ID_W-1:0]  w_idx_acc;
      logic [7:0]       w_a_acc;
      logic [7:0]       w_b_acc;

      assign w_dist[gi] = (DW'(gi) > {1'b0, r_last})
                        ? (DW'(gi) - {1'b0, r_last} - DW'(1))
                        : (DW'(gi) + DW'(N_REQ) - {1'b0, r_last} - DW'(1));

      for (genvar gj = 0; gj < N_REQ; gj++) begin : g_ahead
        assign w_ahead[gj] = (w_dist[gj] < w_dist[gi]);
      end

      assign w_win_oh[gi] = req_i[gi] & ~|(req_i & w_ahead);

      assign w_idx_term = w_win_oh[gi] ? ID_W'(gi) : '0;
      assign w_a_term   = a_bi[8*gi +: 8] & {8{w_win_oh[gi]}};
      assign w_b_term   = b_bi[8*gi +: 8] & {8{w_win_oh[gi]}};

      if (gi == 0) begin : g_first
        assign w_idx_acc = w_idx_term;
        assign w_a_acc   = w_a_term;
        assign w_b_acc   = w_b_term;
      end else begin : g_rest
        assign w_idx_acc = g_req[gi-1].w_idx_acc | w_idx_term;
        assign w_a_acc   = g_req[gi-1].w_a_acc   | w_a_term;
        assign w_b_acc   = g_req[gi-1].w_b_acc   | w_b_term;
      end
    end
  endgenerate

  assign w_win_idx = g_req[N_REQ-1].w_idx_acc;
  assign w_win_a   = g_req[N_REQ-1].w_a_acc;
  assign w_win_b   = g_req[N_REQ-1].w_b_acc;

  // ---------------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state and one-cycle event strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // No grant while the multiplier is still held in reset (first cycle
        // after reset release).
        if (w_any_req && !r_mul_rst) begin
          w_grant      = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_abort) begin
          w_state_next = S_RESP;
        end else if (mul_busy_i) begin
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_abort) begin
          w_state_next = S_RESP;
        end else if (!mul_busy_i) begin
          w_complete   = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: grant, round-robin pointer, operands, result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_gnt    <= '0;
      r_last   <= ID_W'(N_REQ - 1);
      r_mul_a  <= '0;
      r_mul_b  <= '0;
      r_res    <= '0;
      r_res_id <= '0;
    end else begin
      if (w_grant) begin
        r_gnt   <= w_win_oh;
        r_last  <= w_win_idx;
        r_mul_a <= w_win_a;
        r_mul_b <= w_win_b;
      end else if (r_state == S_RESP) begin
        r_gnt   <= '0;
      end

      if (w_complete) begin
        r_res    <= mul_y_bi;
        r_res_id <= r_last;
      end else if (w_abort) begin
        r_res    <= '0;
        r_res_id <= r_last;
      end
    end
  end

  // Multiplier reset: held during reset, released on the first clock edge
  // afterwards, and otherwise only pulsed by the watchdog.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mul_rst <= 1'b1;
    end else begin
      r_mul_rst <= w_wd_fire;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional handshake watchdog
  // ---------------------------------------------------------------------------
`ifdef MULT_ARB_WATCHDOG_EN
  localparam logic [4:0] WD_START_LIM = 5'd4;   // last allowed START cycle index
  localparam logic [4:0] WD_BUSY_LIM  = 5'd15;  // last allowed BUSY cycle index

  logic [4:0] r_wd_cnt;   // cycles spent in the current state, 0 on entry
  logic       r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      // Abort always lands in RESP, so the flag is high exactly there.
      r_err <= w_abort;
      if (w_state_next != r_state) begin
        r_wd_cnt <= '0;
      end else if (r_wd_cnt != 5'h1f) begin
        r_wd_cnt <= r_wd_cnt + 5'd1;
      end
    end
  end

  // Fire one cycle after the limit is exceeded; the multiplier reset pulse
  // then occupies one more cycle of START/BUSY before the FSM moves to RESP.
  assign w_wd_fire = !r_mul_rst &&
                     (((r_state == S_START) && !mul_busy_i && (r_wd_cnt == WD_START_LIM)) ||
                      ((r_state == S_BUSY)  &&  mul_busy_i && (r_wd_cnt == WD_BUSY_LIM)));

  // Inside START/BUSY the multiplier reset can only come from the watchdog.
  assign w_abort = r_mul_rst && ((r_state == S_START) || (r_state == S_BUSY));
  assign err_o   = r_err;
`else
  assign w_wd_fire = 1'b0;
  assign w_abort   = 1'b0;
  assign err_o     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign gnt_o       = r_gnt;
  assign done_o      = (r_state == S_RESP) ? r_gnt : '0;
  assign res_bo      = r_res;
  assign res_id_o    = r_res_id;
  assign mul_a_bo    = r_mul_a;
  assign mul_b_bo    = r_mul_b;
  assign mul_start_o = (r_state == S_START);
  assign mul_rst_o   = r_mul_rst;

endmodule

// File: tb/tb_mult_arb.sv
// -----------------------------------------------------------------------------
// tb_mult_arb
//
// Self-checking bench for mult_arb (N_REQ=4, ID_W=2). Contains a behavioural
// sequential multiplier (busy for 9 cycles after a start, optionally stalled)
// and a round-robin reference model. Build with +define+MULT_ARB_WATCHDOG_EN
// to exercise the watchdog variant.
// -----------------------------------------------------------------------------
module tb_mult_arb;

  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk_i  = 1'b0;
  logic           rst_ni = 1'b0;
  logic [N-1:0]   req_i  = '0;
  logic [8*N-1:0] a_bi   = '0;
  logic [8*N-1:0] b_bi   = '0;
  logic [N-1:0]   gnt_o;
  logic [N-1:0]   done_o;
  logic [15:0]    res_bo;
  logic [IW-1:0]  res_id_o;
  logic           err_o;
  logic [7:0]     mul_a_bo;
  logic [7:0]     mul_b_bo;
  logic           mul_start_o;
  logic           mul_busy_i;
  logic [15:0]    mul_y_bi;
  logic           mul_rst_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  mult_arb #(.N_REQ(N), .ID_W(IW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .a_bi        (a_bi),
    .b_bi        (b_bi),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .res_bo      (res_bo),
    .res_id_o    (res_id_o),
    .err_o       (err_o),
    .mul_a_bo    (mul_a_bo),
    .mul_b_bo    (mul_b_bo),
    .mul_start_o (mul_start_o),
    .mul_busy_i  (mul_busy_i),
    .mul_y_bi    (mul_y_bi),
    .mul_rst_o   (mul_rst_o)
  );

  // Behavioural multiplier: start seen while idle -> busy for 9 cycles,
  // product presented when busy falls. tb_stall keeps it from ever starting.
  logic        tb_stall = 1'b0;
  logic        m_busy   = 1'b0;
  int          m_cnt    = 0;
  logic [15:0] m_prod   = '0;
  logic [15:0] m_y      = '0;

  assign mul_busy_i = m_busy;
  assign mul_y_bi   = m_y;

  always @(posedge clk_i) begin
    if (mul_rst_o) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_y    <= m_prod;
      end
      m_cnt <= m_cnt - 1;
    end else if (mul_start_o && !tb_stall) begin
      m_busy <= 1'b1;
      m_cnt  <= 9;
      m_prod <= mul_a_bo * mul_b_bo;
    end
  end

  typedef struct {
    logic [N-1:0] req;
    logic [7:0]   a;
    logic [7:0]   b;
    int           exp_id;
    logic [15:0]  exp_res;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_op(input int k, input logic [7:0] a, input logic [7:0] b);
    a_bi[8*k +: 8] = a;
    b_bi[8*k +: 8] = b;
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Counts cycles until done_o pulses; lat=-1 if it never does within bound.
  task automatic wait_done(output int lat, output logic [N-1:0] dv);
    lat = -1;
    dv  = '0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (done_o != '0) begin
        lat = n;
        dv  = done_o;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    req_i  = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t         tbl[$];
    int           lat;
    logic [N-1:0] dv;
    int           model_last;
    int           win;
    logic [N-1:0] r;
    logic [31:0]  ra;
    logic [31:0]  rb;
    logic [7:0]   ea;
    logic [7:0]   eb;
    int           seen;
    int           rst_cnt;
    int           rst_at;

    tbl.push_back('{4'b0001, 8'd13,  8'd11,  0, 16'd143});
    tbl.push_back('{4'b0001, 8'hFF,  8'hFF,  0, 16'hFE01});
    tbl.push_back('{4'b0001, 8'h00,  8'hFF,  0, 16'h0000});
    tbl.push_back('{4'b0010, 8'd128, 8'd2,   1, 16'h0100});
    tbl.push_back('{4'b0100, 8'd200, 8'd3,   2, 16'h0258});
    tbl.push_back('{4'b1000, 8'd1,   8'hFF,  3, 16'h00FF});
    tbl.push_back('{4'b1000, 8'hFF,  8'h00,  3, 16'h0000});

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk_i);
    chk("rst_gnt",   32'(gnt_o),       32'h0);
    chk("rst_done",  32'(done_o),      32'h0);
    chk("rst_err",   32'(err_o),       32'h0);
    chk("rst_res",   32'(res_bo),      32'h0);
    chk("rst_id",    32'(res_id_o),    32'h0);
    chk("rst_mula",  32'(mul_a_bo),    32'h0);
    chk("rst_mulb",  32'(mul_b_bo),    32'h0);
    chk("rst_start", 32'(mul_start_o), 32'h0);
    chk("rst_mulrst",32'(mul_rst_o),   32'h1);

    // Requests held across release: no grant on the first edge.
    set_op(0, 8'd9, 8'd7);
    set_op(2, 8'd5, 8'd5);
    req_i  = 4'b0101;
    rst_ni = 1'b1;
    step();
    chk("rel_mulrst", 32'(mul_rst_o),   32'h0);
    chk("rel_nogrant",32'(gnt_o),       32'h0);
    step();
    chk("rel_gnt0",   32'(gnt_o),       32'h1);
    chk("rel_start",  32'(mul_start_o), 32'h1);
    wait_done(lat, dv);
    chk("rel_lat",    32'(lat),     32'd11);
    chk("rel_done",   32'(dv),      32'h1);
    chk("rel_res",    32'(res_bo),  32'd63);
    req_i = '0;
    $display("op release id=%0d res=%04h lat=%0d", res_id_o, res_bo, lat);
    step();

    // ---------------- table vectors: single requester ----------------
    foreach (tbl[i]) begin
      set_op(tbl[i].exp_id, tbl[i].a, tbl[i].b);
      req_i = tbl[i].req;
      wait_done(lat, dv);
      chk("tbl_lat",  32'(lat),      32'd12);
      chk("tbl_done", 32'(dv),       32'(4'b0001 << tbl[i].exp_id));
      chk("tbl_res",  32'(res_bo),   32'(tbl[i].exp_res));
      chk("tbl_id",   32'(res_id_o), 32'(tbl[i].exp_id));
      chk("tbl_err",  32'(err_o),    32'h0);
      $display("op table[%0d] id=%0d a=%02h b=%02h res=%04h lat=%0d",
               i, res_id_o, tbl[i].a, tbl[i].b, res_bo, lat);
      req_i = '0;
      step();
      chk("tbl_pulse1", 32'(done_o),      32'h0);
      chk("tbl_idlegnt",32'(gnt_o),       32'h0);
      chk("tbl_idlest", 32'(mul_start_o), 32'h0);
    end

    // ---------------- owner drops request mid-operation ----------------
    set_op(3, 8'd7, 8'd9);
    req_i = 4'b1000;
    repeat (3) step();
    req_i = '0;
    wait_done(lat, dv);
    chk("drop_lat",  32'(lat),      32'd9);
    chk("drop_done", 32'(dv),       32'h8);
    chk("drop_res",  32'(res_bo),   32'd63);
    chk("drop_id",   32'(res_id_o), 32'd3);
    $display("op owner_drop id=%0d res=%04h lat=%0d", res_id_o, res_bo, lat);
    step();

    // ---------------- reset in the middle of an operation ----------------
    set_op(2, 8'd10, 8'd10);
    req_i = 4'b0100;
    repeat (6) step();
    chk("mid_gnt", 32'(gnt_o), 32'h4);
    rst_ni = 1'b0;
    #1;
    chk("mid_mulrst", 32'(mul_rst_o), 32'h1);
    chk("mid_gntclr", 32'(gnt_o),     32'h0);
    set_op(0, 8'd3, 8'd4);
    set_op(1, 8'd1, 8'd1);
    set_op(3, 8'd2, 8'd2);
    req_i = 4'b1111;
    seen = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (done_o != '0) seen++;
    end
    rst_ni = 1'b1;
    wait_done(lat, dv);
    chk("mid_nodone", 32'(seen),     32'h0);
    chk("mid_lat",    32'(lat),      32'd13);
    chk("mid_next0",  32'(dv),       32'h1);
    chk("mid_res",    32'(res_bo),   32'd12);
    req_i = '0;
    $display("op after_reset id=%0d res=%04h lat=%0d", res_id_o, res_bo, lat);
    step();

    // ---------------- contention: all four held ----------------
    do_reset();
    set_op(0, 8'd2,  8'd3);
    set_op(1, 8'd17, 8'd19);
    set_op(2, 8'hFF, 8'hFE);
    set_op(3, 8'd100,8'd100);
    req_i = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_done(lat, dv);
      chk("cont_lat",  32'(lat),      (j == 0) ? 32'd12 : 32'd13);
      chk("cont_done", 32'(dv),       32'(4'b0001 << (j % 4)));
      chk("cont_id",   32'(res_id_o), 32'(j % 4));
      chk("cont_res",  32'(res_bo),
          32'(16'(a_bi[8*(j%4) +: 8]) * 16'(b_bi[8*(j%4) +: 8])));
      $display("op contention[%0d] id=%0d res=%04h lat=%0d", j, res_id_o, res_bo, lat);
    end
    req_i = '0;
    step();

    // ---------------- randomized against reference model ----------------
    do_reset();
    model_last = N - 1;
    for (int t = 0; t < 30; t++) begin
      r  = 4'($urandom_range(1, 15));
      ra = $urandom;
      rb = $urandom;
      a_bi = ra;
      b_bi = rb;
      win = -1;
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (model_last + i) % N;
        if (win < 0 && ((r >> k) & 4'b0001) != 4'b0000) win = k;
      end
      ea = 8'(ra >> (8 * win));
      eb = 8'(rb >> (8 * win));
      req_i = r;
      wait_done(lat, dv);
      chk("rnd_lat",  32'(lat),      32'd12);
      chk("rnd_done", 32'(dv),       32'(4'b0001 << win));
      chk("rnd_id",   32'(res_id_o), 32'(win));
      chk("rnd_res",  32'(res_bo),   32'(16'(ea) * 16'(eb)));
      $display("op random[%0d] req=%04b id=%0d exp_id=%0d res=%04h", t, r, res_id_o, win, res_bo);
      model_last = win;
      req_i = '0;
      step();
    end

    // ---------------- stalled multiplier ----------------
    do_reset();
    tb_stall = 1'b1;
    set_op(1, 8'd5, 8'd6);
    req_i = 4'b0010;
`ifdef MULT_ARB_WATCHDOG_EN
    rst_cnt = 0;
    rst_at  = -1;
    lat     = -1;
    dv      = '0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (mul_rst_o) begin
        rst_cnt++;
        rst_at = n;
      end
      if (done_o != '0) begin
        lat = n;
        dv  = done_o;
        break;
      end
    end
    chk("wd_lat",    32'(lat),      32'd7);
    chk("wd_done",   32'(dv),       32'h2);
    chk("wd_err",    32'(err_o),    32'h1);
    chk("wd_res",    32'(res_bo),   32'h0);
    chk("wd_id",     32'(res_id_o), 32'd1);
    chk("wd_rstcnt", 32'(rst_cnt),  32'd1);
    chk("wd_rstat",  32'(rst_at),   32'd6);
    $display("op watchdog id=%0d err=%0d res=%04h lat=%0d", res_id_o, err_o, res_bo, lat);
    req_i    = '0;
    tb_stall = 1'b0;
    step();
    chk("wd_errclr", 32'(err_o), 32'h0);
`else
    seen = 0;
    rst_cnt = 0;
    rst_at  = 0;
    repeat (30) begin
      step();
      if (done_o != '0) seen++;
      if (mul_rst_o) rst_cnt++;
      if (err_o) rst_at++;
    end
    chk("stall_nodone", 32'(seen),        32'h0);
    chk("stall_start",  32'(mul_start_o), 32'h1);
    chk("stall_gnt",    32'(gnt_o),       32'h2);
    chk("stall_mulrst", 32'(rst_cnt),     32'h0);
    chk("stall_err",    32'(rst_at),      32'h0);
    $display("op stall start=%0d gnt=%04b", mul_start_o, gnt_o);
    tb_stall = 1'b0;
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
